// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
//
// Runs a multi-layer MLP inference on the shared matrix-vector datapath.
// A small configuration table holds per-layer output count and weight base.
// For each layer the sequencer resets the datapath, launches it, waits for
// completion, latches the flattened result bus and streams the words into
// the ping-pong activation buffer that the next layer reads.
//
// Build option: define MLP_SEQ_RELU_EN to clamp negative words to zero on
// every layer except the last of the run (the last layer writes raw logits).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cfg_we/cfg_layer/
//   cfg_out_size/cfg_wgt_base config table write port (ignored while busy)
//   start, num_layers         run request and layer count
//   mm_done, mm_result        datapath completion level and result bus
//   busy, done                run in progress, end-of-run pulse
//   layer_idx                 current layer
//   mm_rst, mm_start          datapath reset and start pulses
//   mm_wgt_base, mm_in_bank   weight base and input bank for the datapath
//   act_we/act_bank/
//   act_addr/act_wdata        activation buffer write port
//   result_bank               bank holding final outputs
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | datapath reset pulse (clears its held done)
// LAUNCH | datapath start pulse
// WAIT   | waiting for mm_done, latch results
// WRITE  | stream one result word per cycle
// NEXT   | swap banks, advance layer
// FINISH | done pulse, back to IDLE

module mlp_layer_sequencer #(
   parameter int DATA_WIDTH = 27,
   parameter int NUM_LAYERS = 3,
   parameter int MAX_OUT    = 10,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cfg_we,
   input  logic [$clog2(NUM_LAYERS)-1:0]     cfg_layer,
   input  logic [$clog2(MAX_OUT+1)-1:0]      cfg_out_size,
   input  logic [ADDR_WIDTH-1:0]             cfg_wgt_base,
   input  logic                              start,
   input  logic [$clog2(NUM_LAYERS+1)-1:0]   num_layers,
   input  logic                              mm_done,
   input  logic [MAX_OUT*DATA_WIDTH-1:0]     mm_result,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(NUM_LAYERS)-1:0]     layer_idx,
   output logic                              mm_rst,
   output logic                              mm_start,
   output logic [ADDR_WIDTH-1:0]             mm_wgt_base,
   output logic                              mm_in_bank,
   output logic                              act_we,
   output logic                              act_bank,
   output logic [$clog2(MAX_OUT)-1:0]        act_addr,
   output logic [DATA_WIDTH-1:0]             act_wdata,
   output logic                              result_bank
);

   localparam int LW  = $clog2(NUM_LAYERS);
   localparam int LW1 = LW + 1;
   localparam int NW  = $clog2(NUM_LAYERS + 1);
   localparam int OW  = $clog2(MAX_OUT + 1);
   localparam int AW  = $clog2(MAX_OUT);

   localparam logic [NW-1:0]  NUM_LAYERS_N = NW'(NUM_LAYERS);
   localparam logic [LW1-1:0] NUM_LAYERS_C = LW1'(NUM_LAYERS);
   localparam logic [OW-1:0]  MAX_OUT_N    = OW'(MAX_OUT);

   typedef enum logic [2:0] {
      IDLE, CLEAR, LAUNCH, WAIT, WRITE, NEXT, FINISH
   } state_t;

   state_t                 state_q, state_d;
   logic [NW-1:0]          layer_q, layer_d;
   logic [NW-1:0]          num_q, num_d;
   logic                   in_bank_q, in_bank_d;
   logic                   result_bank_q, result_bank_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic                   latch_en;
   logic [DATA_WIDTH-1:0]  res_q [MAX_OUT];

   logic [OW-1:0]          tbl_out_q  [NUM_LAYERS];
   logic [ADDR_WIDTH-1:0]  tbl_base_q [NUM_LAYERS];

   logic                   layer_valid;
   logic [OW-1:0]          cur_out;
   logic [ADDR_WIDTH-1:0]  cur_base;
   logic [OW-1:0]          addr_ext;
   logic [DATA_WIDTH-1:0]  word_sel;
   logic [DATA_WIDTH-1:0]  word_wr;

   // layer_q reaches num_layers in FINISH, which may be one past the table
   assign layer_valid = (layer_q < NUM_LAYERS_N);
   assign cur_out     = layer_valid ? tbl_out_q[layer_q[LW-1:0]]  : '0;
   assign cur_base    = layer_valid ? tbl_base_q[layer_q[LW-1:0]] : '0;
   assign addr_ext    = OW'(addr_q);
   assign word_sel    = res_q[addr_q];

`ifdef MLP_SEQ_RELU_EN
   logic last_layer;
   assign last_layer = ((layer_q + NW'(1)) == num_q);
   assign word_wr    = (!last_layer && word_sel[DATA_WIDTH-1]) ? '0 : word_sel;
`else
   assign word_wr    = word_sel;
`endif

   always_comb begin
      state_d       = state_q;
      layer_d       = layer_q;
      num_d         = num_q;
      in_bank_d     = in_bank_q;
      addr_d        = addr_q;
      result_bank_d = result_bank_q;
      latch_en      = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      mm_rst        = 1'b0;
      mm_start      = 1'b0;
      act_we        = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               num_d     = num_layers;
               layer_d   = '0;
               in_bank_d = 1'b0;
               if ((num_layers == '0) || (num_layers > NUM_LAYERS_N))
                  state_d = FINISH;
               else
                  state_d = CLEAR;
            end
         end
         CLEAR: begin
            mm_rst  = 1'b1;
            state_d = LAUNCH;
         end
         LAUNCH: begin
            mm_start = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (mm_done) begin
               latch_en = 1'b1;
               addr_d   = '0;
               state_d  = (cur_out == '0) ? NEXT : WRITE;
            end
         end
         WRITE: begin
            act_we = 1'b1;
            if ((addr_ext + OW'(1)) == cur_out)
               state_d = NEXT;
            else
               addr_d = addr_q + AW'(1);
         end
         NEXT: begin
            layer_d   = layer_q + NW'(1);
            in_bank_d = ~in_bank_q;
            state_d   = (layer_d == num_q) ? FINISH : CLEAR;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase

      // capture the bank the run ends on, held afterwards for the host
      if (state_d == FINISH)
         result_bank_d = in_bank_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         layer_q       <= '0;
         num_q         <= '0;
         in_bank_q     <= 1'b0;
         result_bank_q <= 1'b0;
         addr_q        <= '0;
         for (int k = 0; k < MAX_OUT; k++)
            res_q[k] <= '0;
      end else begin
         state_q       <= state_d;
         layer_q       <= layer_d;
         num_q         <= num_d;
         in_bank_q     <= in_bank_d;
         result_bank_q <= result_bank_d;
         addr_q        <= addr_d;
         if (latch_en) begin
            for (int k = 0; k < MAX_OUT; k++)
               res_q[k] <= mm_result[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            tbl_out_q[i]  <= '0;
            tbl_base_q[i] <= '0;
         end
      end else if (cfg_we && !busy && ({1'b0, cfg_layer} < NUM_LAYERS_C)) begin
         tbl_out_q[cfg_layer]  <= (cfg_out_size > MAX_OUT_N) ? MAX_OUT_N : cfg_out_size;
         tbl_base_q[cfg_layer] <= cfg_wgt_base;
      end
   end

   assign layer_idx   = layer_q[LW-1:0];
   assign mm_in_bank  = in_bank_q;
   assign act_bank    = ~in_bank_q;
   assign mm_wgt_base = busy ? cur_base : '0;
   // address and data read as zero outside WRITE so idle outputs stay clean
   assign act_addr    = act_we ? addr_q  : '0;
   assign act_wdata   = act_we ? word_wr : '0;
   assign result_bank = result_bank_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
module tb_mlp_layer_sequencer;

   localparam int DW = 27;
   localparam int NL = 3;
   localparam int MO = 10;
   localparam int WA = 16;
   localparam int LW = $clog2(NL);
   localparam int OW = $clog2(MO + 1);
   localparam int NW = $clog2(NL + 1);
   localparam int AA = $clog2(MO);

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [LW-1:0]     cfg_layer;
   logic [OW-1:0]     cfg_out_size;
   logic [WA-1:0]     cfg_wgt_base;
   logic              start;
   logic [NW-1:0]     num_layers;
   logic              mm_done;
   logic [MO*DW-1:0]  mm_result;
   logic              busy, done, mm_rst, mm_start, mm_in_bank;
   logic              act_we, act_bank, result_bank;
   logic [LW-1:0]     layer_idx;
   logic [WA-1:0]     mm_wgt_base;
   logic [AA-1:0]     act_addr;
   logic [DW-1:0]     act_wdata;

   always #5 clk = ~clk;

   mlp_layer_sequencer #(.DATA_WIDTH(DW), .NUM_LAYERS(NL), .MAX_OUT(MO), .ADDR_WIDTH(WA)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
      .cfg_out_size(cfg_out_size), .cfg_wgt_base(cfg_wgt_base),
      .start(start), .num_layers(num_layers), .mm_done(mm_done), .mm_result(mm_result),
      .busy(busy), .done(done), .layer_idx(layer_idx), .mm_rst(mm_rst),
      .mm_start(mm_start), .mm_wgt_base(mm_wgt_base), .mm_in_bank(mm_in_bank),
      .act_we(act_we), .act_bank(act_bank), .act_addr(act_addr),
      .act_wdata(act_wdata), .result_bank(result_bank)
   );

   // datapath model: done rises dp_lat cycles after start, held until mm_rst
   int dp_lat = 2;
   int lat_cnt = 0;
   always @(posedge clk) begin
      if (rst || mm_rst) begin
         mm_done <= 1'b0;
         lat_cnt <= 0;
      end else if (mm_start) begin
         lat_cnt <= dp_lat;
      end else if (lat_cnt > 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) mm_done <= 1'b1;
      end
   end

   logic signed [DW-1:0] res_words [NL][MO];
   always_comb begin
      mm_result = '0;
      if (int'(layer_idx) < NL)
         for (int k = 0; k < MO; k++)
            mm_result[k*DW +: DW] = res_words[int'(layer_idx)][k];
   end

   typedef struct packed {
      logic          bank;
      logic [AA-1:0] addr;
      logic [DW-1:0] data;
      logic [LW-1:0] layer;
   } wr_t;

   wr_t           wq[$];
   logic [WA-1:0] bq[$];
   int            n_rst, n_start, n_done;
   logic          last_rb;

   always @(negedge clk) begin
      if (act_we) wq.push_back('{act_bank, act_addr, act_wdata, layer_idx});
      if (mm_rst) n_rst++;
      if (mm_start) begin n_start++; bq.push_back(mm_wgt_base); end
      if (done) begin n_done++; last_rb = result_bank; end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      wq.delete(); bq.delete();
      n_rst = 0; n_start = 0; n_done = 0; last_rb = 1'bx;
   endtask

   task automatic cfg(input int l, input int o, input int b);
      @(negedge clk);
      cfg_we = 1'b1; cfg_layer = LW'(l); cfg_out_size = OW'(o); cfg_wgt_base = WA'(b);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start(input int num);
      @(negedge clk);
      start = 1'b1; num_layers = NW'(num);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      #1;
      while (n_done == 0 && i < 2000) begin
         @(negedge clk); #1;
         i++;
      end
      chk("done_seen", 64'(n_done), 64'd1);
      @(negedge clk); #1;
   endtask

   task automatic do_run(input int num);
      clear_logs();
      pulse_start(num);
      wait_done();
   endtask

   function automatic logic [DW-1:0] exp_word(input int l, input int k, input int num);
      logic signed [DW-1:0] w;
      w = res_words[l][k];
`ifdef MLP_SEQ_RELU_EN
      if (l != num - 1 && w < 0) w = '0;
`endif
      return w;
   endfunction

   typedef struct {
      int num;
      int out[NL];
      int base[NL];
      int lat;
      int exp_layers;
      int exp_writes;
      logic exp_rb;
   } vec_t;

   vec_t vecs[5];

   localparam logic [DW-1:0] MINUS5 = 27'h7FFFFFB;

   initial begin : main
      logic [DW-1:0] w0;
      int idx, o;

      vecs[0] = '{2, '{4, 2, 0},   '{'h10, 'h40, 'h00},       3, 2, 6,  1'b0};
      vecs[1] = '{1, '{3, 9, 9},   '{'h100, 'h200, 'h300},    1, 1, 3,  1'b1};
      vecs[2] = '{3, '{15, 0, 5},  '{'h1, 'h2, 'h3},          2, 3, 15, 1'b1};
      vecs[3] = '{0, '{2, 2, 2},   '{'h7, 'h8, 'h9},          2, 0, 0,  1'b0};
      vecs[4] = '{3, '{1, 1, 1},   '{'hAAAA, 'h5555, 'hFFFF}, 4, 3, 3,  1'b1};

      for (int l = 0; l < NL; l++)
         for (int k = 0; k < MO; k++) begin
            res_words[l][k] = DW'(l * 1000 + k * 7 + 3);
            if (k % 3 == 2) res_words[l][k] = -res_words[l][k];
         end
      res_words[0][0] = -27'sd5;
      res_words[1][0] = -27'sd5;

      rst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_out_size = '0; cfg_wgt_base = '0;
      start = 1'b0; num_layers = '0;
      clear_logs();
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", 64'({busy, done, mm_rst, mm_start, act_we, act_addr, act_wdata,
                               layer_idx, mm_in_bank, mm_wgt_base, result_bank, act_bank}), 64'd1);
      rst = 1'b0;

      // start-to-pulse latency
      cfg(0, 4, 'h10); cfg(1, 2, 'h40);
      clear_logs(); dp_lat = 3;
      @(negedge clk); start = 1'b1; num_layers = NW'(2);
      @(negedge clk); start = 1'b0; #1;
      chk("t1_busy_rst_start", {busy, mm_rst, mm_start}, 3'b110);
      @(negedge clk); #1;
      chk("t2_busy_rst_start", {busy, mm_rst, mm_start}, 3'b101);
      @(negedge clk); #1;
      chk("t3_busy_rst_start", {busy, mm_rst, mm_start}, 3'b100);
      wait_done();

      // zero-layer run
      clear_logs();
      @(negedge clk); start = 1'b1; num_layers = '0;
      @(negedge clk); start = 1'b0; #1;
      chk("zero_t1_busy_done_rst_we", {busy, done, mm_rst, act_we}, 4'b1100);
      @(negedge clk); #1;
      chk("zero_t2_busy_done", {busy, done}, 2'b00);
      chk("zero_no_rst_no_we", 64'(n_rst + wq.size()), 64'd0);

      // table-driven runs
      foreach (vecs[v]) begin
         for (int l = 0; l < NL; l++) cfg(l, vecs[v].out[l], vecs[v].base[l]);
         dp_lat = vecs[v].lat;
         do_run(vecs[v].num);
         chk($sformatf("v%0d_done_count", v), 64'(n_done), 64'd1);
         chk($sformatf("v%0d_mm_rst_count", v), 64'(n_rst), 64'(vecs[v].exp_layers));
         chk($sformatf("v%0d_mm_start_count", v), 64'(n_start), 64'(vecs[v].exp_layers));
         chk($sformatf("v%0d_result_bank", v), 64'(last_rb), 64'(vecs[v].exp_rb));
         chk($sformatf("v%0d_write_count", v), 64'(wq.size()), 64'(vecs[v].exp_writes));
         idx = 0;
         for (int l = 0; l < vecs[v].num; l++) begin
            if (l < bq.size())
               chk($sformatf("v%0d_l%0d_wgt_base", v, l), 64'(bq[l]), 64'(vecs[v].base[l]));
            o = (vecs[v].out[l] > MO) ? MO : vecs[v].out[l];
            for (int a = 0; a < o; a++) begin
               if (idx < wq.size())
                  chk($sformatf("v%0d_l%0d_w%0d", v, l, a),
                      64'({wq[idx].bank, wq[idx].addr, wq[idx].data}),
                      64'({(l % 2 == 0), AA'(a), exp_word(l, a, vecs[v].num)}));
               idx++;
            end
         end
         if (v == 0 && wq.size() == 6) begin
`ifdef MLP_SEQ_RELU_EN
            w0 = '0;
`else
            w0 = MINUS5;
`endif
            chk("neg5_hidden_layer", 64'(wq[0].data), 64'(w0));
            chk("neg5_last_layer", 64'(wq[4].data), 64'(MINUS5));
         end
      end

      // config writes while busy are dropped
      cfg(0, 3, 'h100);
      clear_logs(); dp_lat = 6;
      pulse_start(1);
      cfg(0, 7, 'h99);
      wait_done();
      chk("busy_cfg_run1_writes", 64'(wq.size()), 64'd3);
      do_run(1);
      chk("busy_cfg_run2_writes", 64'(wq.size()), 64'd3);
      if (bq.size() > 0) chk("busy_cfg_base", 64'(bq[0]), 64'h100);

      // reset in the middle of WRITE
      cfg(0, 4, 'h10); cfg(1, 2, 'h40);
      clear_logs(); dp_lat = 2;
      pulse_start(2);
      idx = 0;
      while (!(act_we && act_addr == AA'(2)) && idx < 200) begin
         @(negedge clk); #1;
         idx++;
      end
      chk("rst_mid_reached_word2", 64'(act_we && act_addr == AA'(2)), 64'd1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rst_mid_outputs", 64'({busy, done, mm_rst, mm_start, act_we, act_addr, act_wdata,
                                 layer_idx, mm_in_bank, mm_wgt_base, result_bank, act_bank}), 64'd1);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("rst_mid_no_more_writes", 64'(wq.size()), 64'd3);
      do_run(1);
      chk("rst_table_cleared_writes", 64'(wq.size()), 64'd0);
      chk("rst_table_cleared_rst", 64'(n_rst), 64'd1);
      cfg(0, 2, 'h33);
      do_run(1);
      chk("rerun_writes", 64'(wq.size()), 64'd2);
      if (bq.size() > 0) chk("rerun_base", 64'(bq[0]), 64'h33);
      if (wq.size() > 0) chk("rerun_layer0", 64'({wq[0].layer, wq[0].bank}), 64'b001);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1, "timeout");
   end

endmodule
